seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit 7-segment display that shares one combinational seg7 decoder across `NUM_DIGITS` digit positions. Digit values are written through a valid/ready port into a shadow buffer and committed to the active buffer at frame boundaries, so a frame never shows a mix of old and new values. The block sits between the counter/datapath logic in the top-level and the `uo_out` segment and anode pins. It drives the shared decoder's input and registers its output.

---
 rtl/seg7_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-coherent digit buffers.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_DIV    = 10000,
    parameter int DEAD_CYCLES = 2,
    localparam int IW         = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [IW-1:0]         wr_idx,
    input  logic [3:0]            wr_data,
    output logic [3:0]            dec_digit,
    input  logic [6:0]            dec_segments,
    output logic [6:0]            seg_out,
    output logic [NUM_DIGITS-1:0] an_out,
    output logic                  frame_tick
);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;

    localparam int MAXC = (TICK_DIV > DEAD_CYCLES) ? TICK_DIV : DEAD_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0]         TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0]         DEAD_LAST = CW'(DEAD_CYCLES - 1);
    localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);

    state_e                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [IW-1:0]           idx_q;
    logic [3:0]              active_q [NUM_DIGITS];
    logic [3:0]              shadow_q [NUM_DIGITS];
    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   an_q;

    logic                    boundary;
    logic                    wr_fire;
    logic                    blank_lz;
    logic [6:0]              seg_d;
    logic [IW-1:0]           idx_d;

    assign boundary   = (state_q == SHOW) && (cnt_q == TICK_LAST) &&
                        (idx_q == IDX_LAST);
    assign frame_tick = boundary;
    assign wr_ready   = !boundary;
    assign wr_fire    = wr_valid && wr_ready && (int'(wr_idx) < NUM_DIGITS);
    assign dec_digit  = active_q[idx_q];
    assign idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    assign seg_out    = seg_q;
    assign an_out     = an_q;

`ifdef SEG7_SCAN_LZB_EN
    // A position blanks when it and every position above it hold zero.
    always_comb begin : lzb
        logic zero_hi;
        zero_hi  = 1'b1;
        blank_lz = 1'b0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_hi = zero_hi && (active_q[k] == 4'd0);
            if (int'(idx_q) == k) blank_lz = zero_hi;
        end
    end
`else
    assign blank_lz = 1'b0;
`endif

    assign seg_d = blank_lz ? 7'd0 : dec_segments;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            seg_q   <= '0;
            an_q    <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                active_q[i] <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            if (wr_fire) shadow_q[wr_idx] <= wr_data;
            if (boundary) active_q <= shadow_q;
            unique case (state_q)
                IDLE: begin
                    active_q <= shadow_q;
                    cnt_q    <= '0;
                    idx_q    <= '0;
                    seg_q    <= '0;
                    an_q     <= '0;
                    if (ena) state_q <= BLANK;
                end
                BLANK: begin
                    if (!ena) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else if (cnt_q == DEAD_LAST) begin
                        state_q <= SHOW;
                        cnt_q   <= '0;
                        an_q    <= AN_ONE << idx_q;
                        seg_q   <= seg_d;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                SHOW: begin
                    if (!ena) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        seg_q   <= '0;
                        an_q    <= '0;
                    end else if (cnt_q == TICK_LAST) begin
                        state_q <= BLANK;
                        cnt_q   <= '0;
                        idx_q   <= idx_d;
                        seg_q   <= '0;
                        an_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a time-based display model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_seg7_scan_ctrl;

    localparam int N = 4;
    localparam int T = 4;
    localparam int D = 1;
    localparam int S = T + D;
    localparam int F = N * S;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       ena;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_idx;
    logic [3:0] wr_data;
    logic [3:0] dec_digit;
    logic [6:0] dec_segments;
    logic [6:0] seg_out;
    logic [3:0] an_out;
    logic       frame_tick;

    logic       ena3;
    logic       wv3;
    logic       rdy3;
    logic [1:0] wi3;
    logic [3:0] wd3;
    logic [3:0] dig3;
    logic [6:0] segin3;
    logic [6:0] segout3;
    logic [2:0] an3;
    logic       ft3;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    assign dec_segments = seg7(dec_digit);
    assign segin3       = seg7(dig3);

    seg7_scan_ctrl #(
        .NUM_DIGITS(N), .TICK_DIV(T), .DEAD_CYCLES(D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_idx(wr_idx), .wr_data(wr_data),
        .dec_digit(dec_digit), .dec_segments(dec_segments),
        .seg_out(seg_out), .an_out(an_out), .frame_tick(frame_tick)
    );

    seg7_scan_ctrl #(
        .NUM_DIGITS(3), .TICK_DIV(T), .DEAD_CYCLES(D)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena3),
        .wr_valid(wv3), .wr_ready(rdy3),
        .wr_idx(wi3), .wr_data(wd3),
        .dec_digit(dig3), .dec_segments(segin3),
        .seg_out(segout3), .an_out(an3), .frame_tick(ft3)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       ft;
        logic       rdy;
        logic [3:0] dig;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Model: t = cycles since enable was sampled (0 = idle).
    int         t;
    logic [3:0] mact  [N];
    logic [3:0] mshad [N];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int   u, k, ph;
        bit   lz;
        e     = '0;
        e.rdy = 1'b1;
        if (t == 0) begin
            e.dig = mact[0];
        end else begin
            u     = (t - 1) % F;
            k     = u / S;
            ph    = u % S;
            e.dig = mact[k];
            e.ft  = (u == F - 1);
            e.rdy = !e.ft;
            if (ph >= D) begin
                e.an = 4'(1 << k);
                lz   = 1'b0;
`ifdef SEG7_SCAN_LZB_EN
                if (k > 0) begin
                    lz = 1'b1;
                    for (int j = k; j < N; j++) if (mact[j] != 4'd0) lz = 1'b0;
                end
`endif
                e.seg = lz ? 7'd0 : seg7(mact[k]);
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < N; i++) begin
            mact[i]  = '0;
            mshad[i] = '0;
        end
    endtask

    task automatic model_step();
        logic [3:0] old [N];
        bit         ft;
        ft  = model_out().ft;
        old = mshad;
        if (wr_valid && !ft) mshad[wr_idx] = wr_data;
        if (t == 0 || ft) mact = old;
        t = ena ? t + 1 : 0;
    endtask

    task automatic tick();
        q.push_back(model_out());
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic write(input int idx, input int data);
        bit acc;
        wr_valid = 1'b1;
        wr_idx   = 2'(idx);
        wr_data  = 4'(data);
        for (int n = 0; n < 4; n++) begin
            acc = model_out().rdy;
            tick();
            if (acc) break;
        end
        wr_valid = 1'b0;
    endtask

    function automatic bit lit_slot(input int k);
        int u;
        if (t == 0) return 1'b0;
        u = (t - 1) % F;
        return (u / S == k) && (u % S >= D);
    endfunction

    task automatic async_reset_pulse();
        rst_n = 1'b0;
        #1;
        model_reset();
        q.push_back(model_out());
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("an_out", 32'(an_out), 32'(e.an));
            chk("seg_out", 32'(seg_out), 32'(e.seg));
            chk("frame_tick", 32'(frame_tick), 32'(e.ft));
            chk("wr_ready", 32'(wr_ready), 32'(e.rdy));
            chk("dec_digit", 32'(dec_digit), 32'(e.dig));
        end
    end

    initial begin
        int c, u3, k3;
        rst_n    = 1'b0;
        ena      = 1'b0;
        wr_valid = 1'b0;
        wr_idx   = '0;
        wr_data  = '0;
        ena3     = 1'b0;
        wv3      = 1'b0;
        wi3      = '0;
        wd3      = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) tick();

        // Narrow instance: in-range digits, then an out-of-range write.
        for (int i = 0; i < 3; i++) begin
            wv3 = 1'b1;
            wi3 = 2'(i);
            wd3 = 4'(i + 1);
            tick();
        end
        wi3 = 2'd3;
        wd3 = 4'd7;
        chk("oor_handshake", 32'(rdy3 & wv3), 32'd1);
        tick();
        wv3  = 1'b0;
        ena3 = 1'b1;
        c    = 0;
        repeat (16) begin
            tick();
            c++;
            u3 = (c - 1) % 15;
            k3 = u3 / 5;
            if (u3 % 5 >= 1) begin
                chk("oor_an", 32'(an3), 32'(1 << k3));
                chk("oor_digit", 32'(dig3), 32'(k3 + 1));
                chk("oor_seg", 32'(segout3), 32'(seg7(4'(k3 + 1))));
            end else begin
                chk("oor_blank", 32'(an3), 32'd0);
            end
        end
        ena3 = 1'b0;

        // Scan order.
        for (int i = 0; i < N; i++) write(i, i + 1);
        tick();
        ena = 1'b1;
        repeat (2 * F) tick();

        // Frame-coherent update mid-frame.
        for (int n = 0; n < 2 * F && !lit_slot(1); n++) tick();
        write(2, 9);
        repeat (2 * F) tick();

        // Enable drop during SHOW of digit 2.
        for (int n = 0; n < 2 * F && !lit_slot(2); n++) tick();
        chk("reach_slot2", 32'(lit_slot(2)), 32'd1);
        ena = 1'b0;
        repeat (2) tick();
        ena = 1'b1;
        repeat (F + 3) tick();

        // Asynchronous reset during SHOW.
        for (int n = 0; n < 2 * F && !lit_slot(1); n++) tick();
        async_reset_pulse();
        repeat (F) tick();

        // Leading zeros: {idx3..0} = {0,0,5,0}.
        ena = 1'b0;
        tick();
        write(0, 0);
        write(1, 5);
        write(2, 0);
        write(3, 0);
        tick();
        ena = 1'b1;
        repeat (2 * F) tick();

        // Randomized traffic.
        repeat (600) begin
            ena      = ($urandom_range(0, 49) != 0);
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_idx   = 2'($urandom_range(0, 3));
            wr_data  = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(0, 15));
            tick();
        end
        wr_valid = 1'b0;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
